// File: rtl/mxbus_reg_slave.sv
// MX bus register slave: independent read and write channels, each running
// IDLE -> ACK -> WAIT -> CPL with a configurable number of wait states.
// Register 0 is a read-only ID constant. Registers 1..NUM_REGS-1 are read/write
// and are exported flat for peripheral logic.
module mxbus_reg_slave #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    NUM_REGS    = 4,
  parameter int                    WAIT_STATES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 8'hA5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s0_wr_txn_start,
  input  logic [ADDR_WIDTH-1:0]          s0_wr_addr,
  input  logic [DATA_WIDTH-1:0]          s0_wr_data,
  output logic                           s0_wr_ready,
  output logic                           s0_wr_txn_ack,
  output logic                           s0_wr_txn_cpl,
  input  logic                           s0_rd_txn_start,
  input  logic [ADDR_WIDTH-1:0]          s0_rd_addr,
  output logic [DATA_WIDTH-1:0]          s0_rd_data,
  output logic                           s0_rd_ready,
  output logic                           s0_rd_txn_ack,
  output logic                           s0_rd_txn_cpl,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  // Counter only has to hold WAIT_STATES; keep at least one bit so the
  // zero-wait build still elaborates.
  localparam int               CNT_W    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_WAIT,
    ST_CPL
  } state_e;

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  state_e                  wr_state_q, wr_state_d;
  logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    wr_ack_q, wr_ack_d;
  logic                    wr_cpl_q, wr_cpl_d;

  // Write FSM next state, request capture, and registered handshake outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; without these, synthesis would infer latches.
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (wr_state_q)
      ST_IDLE: begin
        if (s0_wr_txn_start) begin
          wr_state_d = ST_ACK;
          wr_addr_d  = s0_wr_addr;
          wr_data_d  = s0_wr_data;
        end
      end
      ST_ACK: begin
        wr_cnt_d   = CNT_LOAD;
        wr_state_d = (WAIT_STATES == 0) ? ST_CPL : ST_WAIT;
      end
      ST_WAIT: begin
        wr_cnt_d = wr_cnt_q - CNT_ONE;
        if (wr_cnt_q == CNT_ONE) wr_state_d = ST_CPL;
      end
      ST_CPL:  wr_state_d = ST_IDLE;
      default: wr_state_d = ST_IDLE;
    endcase
    // Outputs are decoded from the next state so they come straight off flops.
    wr_ready_d = (wr_state_d == ST_IDLE);
    wr_ack_d   = (wr_state_d == ST_ACK);
    wr_cpl_d   = (wr_state_d == ST_CPL);
  end

  // Write channel state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_state_q <= ST_IDLE;
      wr_cnt_q   <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_ready_q <= 1'b1;
      wr_ack_q   <= 1'b0;
      wr_cpl_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_ready_q <= wr_ready_d;
      wr_ack_q   <= wr_ack_d;
      wr_cpl_q   <= wr_cpl_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  state_e                  rd_state_q, rd_state_d;
  logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_ready_q, rd_ready_d;
  logic                    rd_ack_q, rd_ack_d;
  logic                    rd_cpl_q, rd_cpl_d;
  logic [DATA_WIDTH-1:0]   rd_sel;

  // Register bank storage; reg 0 is the ID constant and has no storage.
  logic [DATA_WIDTH-1:0]   regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0]   regs_d [1:NUM_REGS-1];

  // Read mux: ID at address 0, stored registers below NUM_REGS, zero beyond.
  always_comb begin
    rd_sel = '0;
    if (rd_addr_q == '0) rd_sel = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rd_addr_q == ADDR_WIDTH'(i)) rd_sel = regs_q[i];
    end
  end

  // Read FSM next state, address capture, data capture on entry to CPL.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    case (rd_state_q)
      ST_IDLE: begin
        if (s0_rd_txn_start) begin
          rd_state_d = ST_ACK;
          rd_addr_d  = s0_rd_addr;
        end
      end
      ST_ACK: begin
        rd_cnt_d   = CNT_LOAD;
        rd_state_d = (WAIT_STATES == 0) ? ST_CPL : ST_WAIT;
      end
      ST_WAIT: begin
        rd_cnt_d = rd_cnt_q - CNT_ONE;
        if (rd_cnt_q == CNT_ONE) rd_state_d = ST_CPL;
      end
      ST_CPL:  rd_state_d = ST_IDLE;
      default: rd_state_d = ST_IDLE;
    endcase
    // Sampling regs_q (not regs_d) makes a same-edge write collision return
    // the pre-write value.
    if (rd_state_d == ST_CPL && rd_state_q != ST_CPL) rd_data_d = rd_sel;
    rd_ready_d = (rd_state_d == ST_IDLE);
    rd_ack_d   = (rd_state_d == ST_ACK);
    rd_cpl_d   = (rd_state_d == ST_CPL);
  end

  // Read channel state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= ST_IDLE;
      rd_cnt_q   <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_ready_q <= 1'b1;
      rd_ack_q   <= 1'b0;
      rd_cpl_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      rd_ready_q <= rd_ready_d;
      rd_ack_q   <= rd_ack_d;
      rd_cpl_q   <= rd_cpl_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  // Commit the captured write at the edge that ends the CPL cycle; address 0
  // and out-of-range addresses match no entry and are dropped.
  always_comb begin
    regs_d = regs_q;
    if (wr_state_q == ST_CPL) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_addr_q == ADDR_WIDTH'(i)) regs_d[i] = wr_data_q;
      end
    end
  end

  // Register bank storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this bank is a handful of control registers, not a RAM, so it
      // is reset as flops; a true memory array would not be reset here.
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Flatten the bank for peripheral logic, with the ID constant in slot 0.
  always_comb begin
    regs_flat                 = '0;
    regs_flat[DATA_WIDTH-1:0] = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  assign s0_wr_ready   = wr_ready_q;
  assign s0_wr_txn_ack = wr_ack_q;
  assign s0_wr_txn_cpl = wr_cpl_q;
  assign s0_rd_ready   = rd_ready_q;
  assign s0_rd_txn_ack = rd_ack_q;
  assign s0_rd_txn_cpl = rd_cpl_q;
  assign s0_rd_data    = rd_data_q;

endmodule

// File: tb/tb_mxbus_reg_slave.sv
// Bench for mxbus_reg_slave: directed transactions against a cycle-timeline
// model of the register slave, plus a zero-wait-state instance.
module tb_mxbus_reg_slave;

  localparam int          NR = 4;
  localparam int          WS = 2;
  localparam logic [7:0]  ID = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        s0_wr_txn_start, s0_wr_ready, s0_wr_txn_ack, s0_wr_txn_cpl;
  logic [7:0]  s0_wr_addr, s0_wr_data;
  logic        s0_rd_txn_start, s0_rd_ready, s0_rd_txn_ack, s0_rd_txn_cpl;
  logic [7:0]  s0_rd_addr, s0_rd_data;
  logic [31:0] regs_flat;

  logic        z_wr_start, z_wr_ready, z_wr_ack, z_wr_cpl;
  logic [7:0]  z_wr_addr, z_wr_data;
  logic        z_rd_start, z_rd_ready, z_rd_ack, z_rd_cpl;
  logic [7:0]  z_rd_addr, z_rd_data;
  logic [31:0] z_regs_flat;

  mxbus_reg_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_REGS(NR),
                    .WAIT_STATES(WS), .ID_VALUE(ID)) dut (
    .clk(clk), .rst(rst),
    .s0_wr_txn_start(s0_wr_txn_start), .s0_wr_addr(s0_wr_addr), .s0_wr_data(s0_wr_data),
    .s0_wr_ready(s0_wr_ready), .s0_wr_txn_ack(s0_wr_txn_ack), .s0_wr_txn_cpl(s0_wr_txn_cpl),
    .s0_rd_txn_start(s0_rd_txn_start), .s0_rd_addr(s0_rd_addr), .s0_rd_data(s0_rd_data),
    .s0_rd_ready(s0_rd_ready), .s0_rd_txn_ack(s0_rd_txn_ack), .s0_rd_txn_cpl(s0_rd_txn_cpl),
    .regs_flat(regs_flat)
  );

  mxbus_reg_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_REGS(NR),
                    .WAIT_STATES(0), .ID_VALUE(ID)) dut_z (
    .clk(clk), .rst(rst),
    .s0_wr_txn_start(z_wr_start), .s0_wr_addr(z_wr_addr), .s0_wr_data(z_wr_data),
    .s0_wr_ready(z_wr_ready), .s0_wr_txn_ack(z_wr_ack), .s0_wr_txn_cpl(z_wr_cpl),
    .s0_rd_txn_start(z_rd_start), .s0_rd_addr(z_rd_addr), .s0_rd_data(z_rd_data),
    .s0_rd_ready(z_rd_ready), .s0_rd_txn_ack(z_rd_ack), .s0_rd_txn_cpl(z_rd_cpl),
    .regs_flat(z_regs_flat)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: cyc counts edges; the cycle right after edge E has cyc == E+1, so a
  // start driven while cyc == n is sampled at edge n. Transactions are kept as
  // their start edge; every output follows from that plus WS.
  // ---------------------------------------------------------------------------
  int         cyc = 0;
  bit         chk_en = 1'b0;
  logic [7:0] m_regs [NR];
  int         wr_n, rd_n;
  logic [7:0] wr_a, wr_d, rd_a, rd_pend, exp_rd;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a == 8'd0) return ID;
    if (int'(a) < NR) return m_regs[int'(a)];
    return 8'h00;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    wr_n = -1000; rd_n = -1000;
    rd_pend = 8'h00; exp_rd = 8'h00;
  endtask

  // Per-cycle compare of every DUT output against the model, 1 time unit
  // after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (chk_en) begin
        if (cyc == wr_n + 3 + WS && wr_a != 8'd0 && int'(wr_a) < NR) m_regs[int'(wr_a)] = wr_d;
        if (cyc == rd_n + 2 + WS) exp_rd = rd_pend;
        if (cyc == rd_n + 1 + WS) rd_pend = m_read(rd_a);
        check("wr_ready", s0_wr_ready,   !(cyc >= wr_n + 1 && cyc <= wr_n + 2 + WS));
        check("wr_ack",   s0_wr_txn_ack, cyc == wr_n + 1);
        check("wr_cpl",   s0_wr_txn_cpl, cyc == wr_n + 2 + WS);
        check("rd_ready", s0_rd_ready,   !(cyc >= rd_n + 1 && cyc <= rd_n + 2 + WS));
        check("rd_ack",   s0_rd_txn_ack, cyc == rd_n + 1);
        check("rd_cpl",   s0_rd_txn_cpl, cyc == rd_n + 2 + WS);
        check("rd_data",  s0_rd_data,    exp_rd);
        check("regs_flat", regs_flat,    {m_regs[3], m_regs[2], m_regs[1], ID});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers: inputs change on the falling edge; start held until ack.
  // ---------------------------------------------------------------------------
  task automatic wr_txn(input logic [7:0] a, input logic [7:0] d,
                        output int n, output int ack_c, output int cpl_c);
    ack_c = -1; cpl_c = -1;
    @(negedge clk);
    for (int k = 0; k < 50 && !s0_wr_ready; k++) @(negedge clk);
    n = cyc; wr_n = cyc; wr_a = a; wr_d = d;
    s0_wr_txn_start = 1'b1; s0_wr_addr = a; s0_wr_data = d;
    for (int k = 0; k < 50 && ack_c < 0; k++) begin
      @(negedge clk);
      if (s0_wr_txn_ack) ack_c = cyc;
    end
    s0_wr_txn_start = 1'b0;
    if (ack_c < 0) check("wr_ack_timeout", 0, 1);
    for (int k = 0; k < 50 && cpl_c < 0; k++) begin
      @(negedge clk);
      if (s0_wr_txn_cpl) cpl_c = cyc;
    end
    if (cpl_c < 0) check("wr_cpl_timeout", 0, 1);
  endtask

  task automatic rd_txn(input logic [7:0] a, output int n, output int ack_c,
                        output int cpl_c, output logic [7:0] d);
    ack_c = -1; cpl_c = -1; d = 8'hxx;
    @(negedge clk);
    for (int k = 0; k < 50 && !s0_rd_ready; k++) @(negedge clk);
    n = cyc; rd_n = cyc; rd_a = a;
    s0_rd_txn_start = 1'b1; s0_rd_addr = a;
    for (int k = 0; k < 50 && ack_c < 0; k++) begin
      @(negedge clk);
      if (s0_rd_txn_ack) ack_c = cyc;
    end
    s0_rd_txn_start = 1'b0;
    if (ack_c < 0) check("rd_ack_timeout", 0, 1);
    for (int k = 0; k < 50 && cpl_c < 0; k++) begin
      @(negedge clk);
      if (s0_rd_txn_cpl) begin
        cpl_c = cyc;
        d = s0_rd_data;
      end
    end
    if (cpl_c < 0) check("rd_cpl_timeout", 0, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence with hand-computed literal expectations.
  // ---------------------------------------------------------------------------
  int         n, a_c, c_c, n2, a2, c2;
  logic [7:0] d;

  initial begin
    s0_wr_txn_start = 1'b0; s0_wr_addr = '0; s0_wr_data = '0;
    s0_rd_txn_start = 1'b0; s0_rd_addr = '0;
    z_wr_start = 1'b0; z_wr_addr = '0; z_wr_data = '0;
    z_rd_start = 1'b0; z_rd_addr = '0;
    m_reset();

    // Reset values, while reset is still asserted and right after release.
    repeat (3) @(negedge clk);
    check("rst_wr_ready", s0_wr_ready, 1'b1);
    check("rst_rd_data",  s0_rd_data,  8'h00);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("init_flat",     regs_flat,   32'h000000A5);
    check("init_rd_ready", s0_rd_ready, 1'b1);
    check("init_acks",     {s0_wr_txn_ack, s0_wr_txn_cpl, s0_rd_txn_ack, s0_rd_txn_cpl}, 4'b0000);

    // Write 02 <- 3C: ack at +1, cpl at +4, visible and ready at +5.
    wr_txn(8'h02, 8'h3C, n, a_c, c_c);
    check("w2_ack_cyc", a_c - n, 1);
    check("w2_cpl_cyc", c_c - n, 4);
    @(negedge clk);
    check("w2_ready", s0_wr_ready, 1'b1);
    check("w2_flat",  regs_flat,   32'h003C00A5);

    // Reads: stored register, ID register, out of range.
    rd_txn(8'h02, n, a_c, c_c, d);
    check("r2_ack_cyc", a_c - n, 1);
    check("r2_cpl_cyc", c_c - n, 4);
    check("r2_data", d, 8'h3C);
    rd_txn(8'h00, n, a_c, c_c, d);
    check("r0_data", d, 8'hA5);
    rd_txn(8'h09, n, a_c, c_c, d);
    check("r9_data", d, 8'h00);

    // Writes to the ID register and out of range are dropped with a full handshake.
    wr_txn(8'h00, 8'hFF, n, a_c, c_c);
    check("w0_cpl_cyc", c_c - n, 4);
    wr_txn(8'h09, 8'h77, n, a_c, c_c);
    check("w9_cpl_cyc", c_c - n, 4);
    @(negedge clk);
    check("w09_flat", regs_flat, 32'h003C00A5);
    rd_txn(8'h00, n, a_c, c_c, d);
    check("r0_after_w0", d, 8'hA5);

    // Collision: read of reg1 and write 22 start on the same edge.
    wr_txn(8'h01, 8'h11, n, a_c, c_c);
    fork
      wr_txn(8'h01, 8'h22, n, a_c, c_c);
      rd_txn(8'h01, n2, a2, c2, d);
    join
    check("coll_same_edge", n2, n);
    check("coll_rd_data", d, 8'h11);
    @(negedge clk);
    check("coll_flat", regs_flat, 32'h003C22A5);
    rd_txn(8'h01, n, a_c, c_c, d);
    check("coll_reread", d, 8'h22);

    // Reset during the WAIT phase of a write to reg3.
    @(negedge clk);
    for (int k = 0; k < 50 && !s0_wr_ready; k++) @(negedge clk);
    n = cyc; wr_n = cyc; wr_a = 8'h03; wr_d = 8'h5A;
    s0_wr_txn_start = 1'b1; s0_wr_addr = 8'h03; s0_wr_data = 8'h5A;
    @(negedge clk);
    check("rw_ack", s0_wr_txn_ack, 1'b1);
    s0_wr_txn_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    #1;
    check("rw_ready_now", s0_wr_ready, 1'b1);
    check("rw_no_cpl",    s0_wr_txn_cpl, 1'b0);
    check("rw_rd_data",   s0_rd_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rw_flat", regs_flat, 32'h000000A5);
    rd_txn(8'h03, n, a_c, c_c, d);
    check("rw_r3", d, 8'h00);

    // Zero-wait-state build: ack at +1, cpl at +2, ready and data at +3.
    @(negedge clk);
    z_wr_start = 1'b1; z_wr_addr = 8'h01; z_wr_data = 8'h5A;
    @(negedge clk);
    check("z_wr_ack", {z_wr_ack, z_wr_cpl, z_wr_ready}, 3'b100);
    z_wr_start = 1'b0;
    @(negedge clk);
    check("z_wr_cpl", {z_wr_ack, z_wr_cpl, z_wr_ready}, 3'b010);
    @(negedge clk);
    check("z_wr_ready", z_wr_ready, 1'b1);
    check("z_flat", z_regs_flat, 32'h00005AA5);
    z_rd_start = 1'b1; z_rd_addr = 8'h01;
    @(negedge clk);
    check("z_rd_ack", {z_rd_ack, z_rd_cpl}, 2'b10);
    z_rd_start = 1'b0;
    @(negedge clk);
    check("z_rd_cpl", {z_rd_ack, z_rd_cpl}, 2'b01);
    check("z_rd_data", z_rd_data, 8'h5A);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mxbus_reg_slave.md
Name: mxbus_reg_slave

Overview:
- MX bus responder (s0_ side) with independent read and write channels, fronting a small control/status register bank.
- Pairs with any mxbiu_* master. Used as the peripheral register slave next to mxbus_rom/mxbus_ram in the test and system fabrics.
- Parameterised wait-state latency lets BIU masters be exercised against slow slaves.
- Register contents are exported flat for peripheral logic.

Parameters:
- ADDR_WIDTH, 8, MX bus address width.
- DATA_WIDTH, 8, MX bus data width and register width.
- NUM_REGS, 4, registers implemented at addresses 0..NUM_REGS-1. Must be ≥2 and ≤2**ADDR_WIDTH.
- WAIT_STATES, 2, extra cycles between ack and cpl on both channels. 0 is legal.
- ID_VALUE, 8'hA5, constant returned by read-only register 0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s0_wr_txn_start  in  1  master requests a write. Held until s0_wr_txn_ack.
- s0_wr_addr  in  ADDR_WIDTH  write address, valid while s0_wr_txn_start=1
- s0_wr_data  in  DATA_WIDTH  write data, valid while s0_wr_txn_start=1
- s0_wr_ready  out  1  write channel idle, able to accept a request
- s0_wr_txn_ack  out  1  one-cycle pulse: write address/data captured
- s0_wr_txn_cpl  out  1  one-cycle pulse: write committed
- s0_rd_txn_start  in  1  master requests a read. Held until s0_rd_txn_ack.
- s0_rd_addr  in  ADDR_WIDTH  read address, valid while s0_rd_txn_start=1
- s0_rd_data  out  DATA_WIDTH  read data, valid in the s0_rd_txn_cpl cycle, held until the next read completes
- s0_rd_ready  out  1  read channel idle
- s0_rd_txn_ack  out  1  one-cycle pulse: read address captured
- s0_rd_txn_cpl  out  1  one-cycle pulse: s0_rd_data valid
- regs_flat  out  NUM_REGS*DATA_WIDTH  register bank, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- One clock, clk. Reset rst is asynchronous, active-high. All outputs are registered.
- Reset values:
  - ready outputs = 1
  - ack and cpl outputs = 0
  - s0_rd_data = 0
  - regs 1..NUM_REGS-1 = 0; reg 0 always reads ID_VALUE (also in regs_flat)
  - both FSMs in IDLE, wait counters = 0
- Per-channel FSM (write and read identical, fully independent): IDLE -> ACK -> WAIT -> CPL -> IDLE.
  - IDLE: ready=1. start sampled high at edge N -> ACK during cycle N+1. Address (and write data) latched at edge N. ready=0 from N+1.
  - ACK: ack=1 for one cycle. Counter loaded with WAIT_STATES. Go to WAIT, or straight to CPL if WAIT_STATES=0.
  - WAIT: counter decrements each cycle. Go to CPL when counter reaches 1.
  - CPL: cpl=1 for one cycle, then IDLE. ready=1 from the following cycle.
  - Latency: start sampled at edge N -> ack in cycle N+1 -> cpl in cycle N+2+WAIT_STATES -> ready high in N+3+WAIT_STATES.
  - Back-to-back throughput: one transaction per 3+WAIT_STATES cycles per channel.
- start while not IDLE is ignored. The master must drop start in the cycle after ack; a start still high in IDLE is a new transaction.
- Write commit: register updated at the edge ending the CPL cycle. regs_flat reflects the new value from cycle N+3+WAIT_STATES.
- Address decode:
  - Write to addr 0 or addr ≥ NUM_REGS: dropped silently, but full ack/cpl handshake still occurs.
  - Read of addr ≥ NUM_REGS returns 0 with normal handshake.
- s0_rd_data is captured at the edge entering CPL.
- Read/write collision: if read capture and write commit target the same register on the same edge, the read returns the pre-write value.
- rst asserted mid-transaction: immediate return to reset values. Pending write not committed, no cpl emitted, s0_rd_data cleared. No recovery handshake; master BIU is reset with the same rst.
- No error response; the bus has no error signalling.

Test Plan:
(defaults: ADDR_WIDTH=8, DATA_WIDTH=8, NUM_REGS=4, WAIT_STATES=2, ID_VALUE=8'hA5; start sampled at edge 0)
- Reset release -> both ready=1, acks/cpls=0, s0_rd_data=00, regs_flat=32'h000000A5.
- Write addr 02 data 3C, start held until ack -> s0_wr_txn_ack in cycle 1, s0_wr_txn_cpl in cycle 4, s0_wr_ready=1 in cycle 5, regs_flat[23:16]=3C from cycle 5.
- Read addr 02 after the above -> s0_rd_txn_ack in cycle 1, s0_rd_txn_cpl in cycle 4 with s0_rd_data=3C. Read addr 00 -> A5. Read addr 09 -> 00.
- Write addr 00 data FF, then write addr 09 data 77 -> both complete handshakes with cpl at cycle 4. regs_flat unchanged, read addr 00 still A5.
- Reg1=11. Simultaneous write addr 01 data 22 and read addr 01 at edge 0 -> read cpl data 11, regs_flat[15:8]=22 from cycle 5. Subsequent read returns 22.
- Write addr 03 data 5A, rst pulsed in cycle 2 (WAIT) -> no s0_wr_txn_cpl, reg3=00, ready=1 immediately. WAIT_STATES=0 build: cpl in cycle 2.
